// File: rtl/judge_pkg.sv
// Shared judgement codes, point values and round-control states for the lane judge.
package judge_pkg;

   localparam logic [1:0] JUDGE_NONE    = 2'b00;
   localparam logic [1:0] JUDGE_PERFECT = 2'b01;
   localparam logic [1:0] JUDGE_GOOD    = 2'b10;
   localparam logic [1:0] JUDGE_MISS    = 2'b11;

   localparam int PERFECT_PTS = 2;
   localparam int GOOD_PTS    = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, searching upward with wrap.
// Zero latency; ptr must be below LANES.
module rr_pick #(
   parameter int LANES = 4,
   parameter int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic [LANES-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [LANES-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             hit
);

   always_comb begin
      int slot;
      gnt  = '0;
      idx  = '0;
      hit  = 1'b0;
      slot = 0;
      for (int k = 0; k < LANES; k++) begin
         slot = (int'(ptr) + k) % LANES;
         if (!hit && req[slot]) begin
            gnt[slot] = 1'b1;
            idx       = IDX_W'(slot);
            hit       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/judge_arbiter.sv
// Per-lane one-entry judgement slots retired round-robin, one per cycle, into saturating score/combo.
// Arrival to accumulator update is one edge; a full, ungranted slot drops the arrival and flags it.
module judge_arbiter
   import judge_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int SCORE_W = 8,
   parameter int COMBO_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [LANES-1:0]     judge_valid,
   input  logic [2*LANES-1:0]   judge_code,
   output logic [LANES-1:0]     pending,
   output logic [LANES-1:0]     grant,
   output logic [LANES-1:0]     dropped,
   output logic                 busy,
   output logic                 done,
   output logic [SCORE_W-1:0]   score,
   output logic [COMBO_W-1:0]   combo,
   output logic [COMBO_W-1:0]   max_combo
);

   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W-1:0]  ptr_next;
   logic [LANES-1:0]  pick_gnt;
   logic              pick_hit;
   logic              granted;
   logic [LANES-1:0]  accept;
   logic [LANES-1:0]  pending_next;
   logic [1:0]        slot_code [LANES];
   logic [1:0]        ret_code;

   logic [SCORE_W:0]   pts;
   logic [SCORE_W:0]   score_sum;
   logic [SCORE_W-1:0] score_nx;
   logic [COMBO_W-1:0] combo_nx;
   logic [COMBO_W-1:0] max_nx;

   rr_pick #(
      .LANES (LANES),
      .IDX_W (IDX_W)
   ) u_pick (
      .req (pending),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .hit (pick_hit)
   );

   assign busy     = (state != IDLE);
   assign granted  = busy && pick_hit;
   assign grant    = busy ? pick_gnt : '0;
   assign ret_code = slot_code[pick_idx];
   assign ptr_next = (pick_idx == IDX_W'(LANES - 1)) ? '0 : pick_idx + IDX_W'(1);

   always_comb begin
      accept = '0;
      for (int i = 0; i < LANES; i++) begin
         accept[i] = (state == RUN) && enable && judge_valid[i] &&
                     (judge_code[2*i +: 2] != JUDGE_NONE);
      end
   end

   // Slot occupancy after the coming edge; lets the FSM leave DRAIN on the retiring edge itself.
   assign pending_next = clear ? '0 : (accept | (pending & ~grant));

   always_comb begin
      pts      = '0;
      combo_nx = combo;
      case (ret_code)
         JUDGE_PERFECT: begin
            pts      = (SCORE_W+1)'(PERFECT_PTS);
            combo_nx = (combo == '1) ? combo : combo + COMBO_W'(1);
         end
         JUDGE_GOOD: pts      = (SCORE_W+1)'(GOOD_PTS);
         JUDGE_MISS: combo_nx = '0;
         default:    ;
      endcase
      score_sum = {1'b0, score} + pts;
      score_nx  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      max_nx    = (combo_nx > max_combo) ? combo_nx : max_combo;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         dropped <= '0;
         rr_ptr  <= '0;
         for (int i = 0; i < LANES; i++) slot_code[i] <= JUDGE_NONE;
      end else if (clear) begin
         pending <= '0;
         dropped <= '0;
         rr_ptr  <= '0;
         for (int i = 0; i < LANES; i++) slot_code[i] <= JUDGE_NONE;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (accept[i] && (!pending[i] || grant[i])) begin
               slot_code[i] <= judge_code[2*i +: 2];
               pending[i]   <= 1'b1;
            end else if (accept[i]) begin
               dropped[i] <= 1'b1;
            end else if (grant[i]) begin
               pending[i] <= 1'b0;
            end
         end
         if (granted) rr_ptr <= ptr_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score     <= '0;
         combo     <= '0;
         max_combo <= '0;
      end else if (clear) begin
         score     <= '0;
         combo     <= '0;
         max_combo <= '0;
      end else if (granted) begin
         score     <= score_nx;
         combo     <= combo_nx;
         max_combo <= max_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) state <= RUN;
            end
            RUN: begin
               if (!enable) begin
                  if (pending_next == '0) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (enable) begin
                  state <= RUN;
               end else if (pending_next == '0) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_judge_arbiter.sv
// Directed bench for judge_arbiter: vector table plus saturation and async-reset sequences.
module tb_judge_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic       enable;
   logic [3:0] judge_valid;
   logic [7:0] judge_code;
   logic [3:0] pending;
   logic [3:0] grant;
   logic [3:0] dropped;
   logic       busy;
   logic       done;
   logic [7:0] score;
   logic [7:0] combo;
   logic [7:0] max_combo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en;
      logic       clr;
      logic [3:0] vld;
      logic [7:0] code;
      logic [3:0] pend;
      logic [3:0] gnt;
      logic [3:0] drop;
      logic       bsy;
      logic       dn;
      logic [7:0] scr;
      logic [7:0] cmb;
      logic [7:0] mxc;
   } vec_t;

   vec_t vecs[$];

   judge_arbiter #(
      .LANES   (4),
      .SCORE_W (8),
      .COMBO_W (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .enable      (enable),
      .judge_valid (judge_valid),
      .judge_code  (judge_code),
      .pending     (pending),
      .grant       (grant),
      .dropped     (dropped),
      .busy        (busy),
      .done        (done),
      .score       (score),
      .combo       (combo),
      .max_combo   (max_combo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] pend, input logic [3:0] gnt,
                          input logic [3:0] drop, input logic bsy, input logic dn,
                          input logic [7:0] scr, input logic [7:0] cmb, input logic [7:0] mxc);
      chk({tag, ".pending"},   32'(pending),   32'(pend));
      chk({tag, ".grant"},     32'(grant),     32'(gnt));
      chk({tag, ".dropped"},   32'(dropped),   32'(drop));
      chk({tag, ".busy"},      32'(busy),      32'(bsy));
      chk({tag, ".done"},      32'(done),      32'(dn));
      chk({tag, ".score"},     32'(score),     32'(scr));
      chk({tag, ".combo"},     32'(combo),     32'(cmb));
      chk({tag, ".max_combo"}, 32'(max_combo), 32'(mxc));
   endtask

   task automatic add(input logic en, input logic clr, input logic [3:0] vld, input logic [7:0] code,
                      input logic [3:0] pend, input logic [3:0] gnt, input logic [3:0] drop,
                      input logic bsy, input logic dn,
                      input logic [7:0] scr, input logic [7:0] cmb, input logic [7:0] mxc);
      vec_t v;
      v.en = en;   v.clr = clr; v.vld = vld; v.code = code;
      v.pend = pend; v.gnt = gnt; v.drop = drop; v.bsy = bsy; v.dn = dn;
      v.scr = scr; v.cmb = cmb; v.mxc = mxc;
      vecs.push_back(v);
   endtask

   // Stream n copies of one code on lane 0, then one idle cycle so the last one retires.
   task automatic stream_lane0(input int n, input logic [1:0] code);
      for (int k = 0; k < n; k++) begin
         judge_valid = 4'b0001;
         judge_code  = {6'b0, code};
         tick();
      end
      judge_valid = '0;
      judge_code  = '0;
      tick();
   endtask

   initial begin
      reset       = 1'b1;
      clear       = 1'b0;
      enable      = 1'b0;
      judge_valid = '0;
      judge_code  = '0;

      //   en clr vld   code   pend  gnt   drop  bsy dn  scr  cmb  max
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1, 0,   0,   0,   0);  // IDLE->RUN
      add(1, 0, 4'h1, 8'h01, 4'h1, 4'h1, 4'h0, 1, 0,   0,   0,   0);  // lane0 PERFECT
      add(1, 0, 4'h1, 8'h01, 4'h1, 4'h1, 4'h0, 1, 0,   2,   1,   1);  // PERFECT, refill
      add(1, 0, 4'h1, 8'h02, 4'h1, 4'h1, 4'h0, 1, 0,   4,   2,   2);  // GOOD, refill
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1, 0,   5,   2,   2);
      add(1, 0, 4'h4, 8'h30, 4'h4, 4'h4, 4'h0, 1, 0,   5,   2,   2);  // lane2 MISS
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1, 0,   5,   0,   2);
      add(1, 1, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1, 0,   0,   0,   0);  // clear, ptr->0
      add(1, 0, 4'hF, 8'h55, 4'hF, 4'h1, 4'h0, 1, 0,   0,   0,   0);  // all lanes PERFECT
      add(1, 0, 4'h0, 8'h00, 4'hE, 4'h2, 4'h0, 1, 0,   2,   1,   1);
      add(1, 0, 4'h0, 8'h00, 4'hC, 4'h4, 4'h0, 1, 0,   4,   2,   2);
      add(1, 0, 4'h0, 8'h00, 4'h8, 4'h8, 4'h0, 1, 0,   6,   3,   3);
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1, 0,   8,   4,   4);
      add(1, 0, 4'hA, 8'h44, 4'hA, 4'h2, 4'h0, 1, 0,   8,   4,   4);  // lanes 1,3: lane1 first
      add(1, 0, 4'h0, 8'h00, 4'h8, 4'h8, 4'h0, 1, 0,  10,   5,   5);
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1, 0,  12,   6,   6);
      add(1, 0, 4'h3, 8'h06, 4'h3, 4'h1, 4'h0, 1, 0,  12,   6,   6);  // lane0 GOOD, lane1 PERFECT
      add(1, 0, 4'h2, 8'h04, 4'h2, 4'h2, 4'h2, 1, 0,  13,   6,   6);  // lane1 again: dropped
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h2, 1, 0,  15,   7,   7);
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h2, 1, 0,  15,   7,   7);  // drop flag sticky
      add(1, 0, 4'hB, 8'h45, 4'hB, 4'h8, 4'h2, 1, 0,  15,   7,   7);  // lanes 0,1,3 pending
      add(0, 0, 4'h4, 8'h10, 4'h3, 4'h1, 4'h2, 1, 0,  17,   8,   8);  // enable falls -> DRAIN
      add(0, 0, 4'hF, 8'h55, 4'h2, 4'h2, 4'h2, 1, 0,  19,   9,   9);  // arrivals ignored in DRAIN
      add(0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h2, 0, 1,  21,  10,  10);  // last retire -> done
      add(0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h2, 0, 0,  21,  10,  10);
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h2, 1, 0,  21,  10,  10);
      add(1, 1, 4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 1, 0,   0,   0,   0);  // clear beats arrival
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 1, 0,   0,   0,   0);

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk_all("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         enable      = vecs[i].en;
         clear       = vecs[i].clr;
         judge_valid = vecs[i].vld;
         judge_code  = vecs[i].code;
         tick();
         chk_all($sformatf("row%0d", i), vecs[i].pend, vecs[i].gnt, vecs[i].drop,
                 vecs[i].bsy, vecs[i].dn, vecs[i].scr, vecs[i].cmb, vecs[i].mxc);
      end
      clear       = 1'b0;
      judge_valid = '0;
      judge_code  = '0;

      stream_lane0(127, 2'b01);
      chk("sat.score_254", 32'(score), 32'd254);
      chk("sat.combo_127", 32'(combo), 32'd127);
      stream_lane0(1, 2'b01);
      chk("sat.score_max", 32'(score), 32'd255);
      chk("sat.combo_128", 32'(combo), 32'd128);
      stream_lane0(127, 2'b01);
      chk("sat.combo_255", 32'(combo), 32'd255);
      stream_lane0(1, 2'b01);
      chk("sat.score_hold", 32'(score), 32'd255);
      chk("sat.combo_hold", 32'(combo), 32'd255);
      chk("sat.max_hold",   32'(max_combo), 32'd255);
      stream_lane0(1, 2'b10);
      chk("sat.good_score", 32'(score), 32'd255);
      stream_lane0(1, 2'b11);
      chk("sat.miss_combo", 32'(combo), 32'd0);
      chk("sat.miss_max",   32'(max_combo), 32'd255);

      // Three lanes pending, enable drops, then reset lands mid-cycle during DRAIN.
      judge_valid = 4'b0111;
      judge_code  = 8'h15;
      tick();
      judge_valid = '0;
      judge_code  = '0;
      enable      = 1'b0;
      tick();
      chk("drain.busy",    32'(busy),    32'd1);
      chk("drain.pending", 32'(pending), 32'h5);
      #3;
      reset = 1'b1;
      #1;
      chk("arst.busy",    32'(busy),    32'd0);
      chk("arst.pending", 32'(pending), 32'd0);
      chk("arst.score",   32'(score),   32'd0);
      chk("arst.done",    32'(done),    32'd0);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("arst.no_done%0d", k), 32'(done), 32'd0);
         chk($sformatf("arst.idle%0d", k),    32'(busy), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/judge_arbiter.md
# judge_arbiter

Shares one score/combo accumulator among LANES note lanes. Each lane posts a 2-bit judgement (none/perfect/good/miss) into a one-entry holding slot. A round-robin arbiter retires at most one judgement per cycle into the running score, combo and max-combo registers. A small run/drain FSM lets the game-round controller stop play cleanly, with every accepted judgement counted before results are shown.

## Interface
- LANES, 4: number of lanes (2..8)
- SCORE_W, 8: score width
- COMBO_W, 8: combo and max-combo width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state to reset values
- clear  in  1  synchronous clear of accumulators, slots, drop flags, pointer
- enable  in  1  round active; arrivals accepted only while high
- judge_valid  in  LANES  per-lane one-cycle strobe
- judge_code  in  2*LANES  lane i code at bits [2i+1:2i]
- pending  out  LANES  slot i holds an unretired judgement
- grant  out  LANES  one-hot lane retired at the coming edge; combinational from registers
- dropped  out  LANES  sticky; lane i lost a judgement to a full slot
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse on DRAIN→IDLE
- score  out  SCORE_W  accumulated score
- combo  out  COMBO_W  current combo
- max_combo  out  COMBO_W  highest combo this round

## Operation
- Codes: 00 NONE, 01 PERFECT (+2 score, combo+1), 10 GOOD (+1 score, combo unchanged), 11 MISS (combo←0).
- Reset/clear values: all outputs 0. FSM=IDLE, rr_ptr=0, slots empty.
- FSM IDLE→RUN when enable=1.
- FSM RUN→DRAIN when enable=0. In the same cycle the machine goes to IDLE and pulses done if no slot is pending.
- FSM DRAIN→IDLE when pending==0; done=1 for that one cycle.
- FSM DRAIN→RUN if enable reasserts.
- Arrival is accepted when the FSM is in RUN with enable=1, judge_valid[i]=1 and code≠NONE. A NONE code is ignored entirely.
- Slot i empty, or granted this cycle: the slot is loaded with the arrival and pending stays or becomes 1.
- Slot i full and not granted: the arrival is discarded and dropped[i] is set.
- Arrivals in IDLE or DRAIN are ignored and do not set dropped.
- Arbitration runs in RUN and DRAIN. grant is the first pending lane at or after rr_ptr, searching upward with wrap.
- On a grant, rr_ptr←(granted index+1) mod LANES. With no grant, rr_ptr holds.
- Retire: the granted code is applied at the edge and its slot is cleared, unless it is refilled by a same-cycle arrival.
- Arithmetic: score saturates at 2^SCORE_W−1; a +2 from max−1 gives max. combo saturates at 2^COMBO_W−1.
- max_combo←max(max_combo, new combo) at the same edge as the combo update, with no one-cycle lag.
- clear has priority over arrivals and grants in the same cycle. The FSM is not affected by clear.

## Timing
- An arrival sampled at edge k sets pending after k. The earliest grant is the cycle after k. score, combo and max_combo update at edge k+1.
- Throughput: one retirement per cycle. A single lane streaming every cycle sustains full rate, because of refill-on-grant.
- Worst-case wait for a pending lane is LANES cycles.
- done asserts the cycle after the edge on which the last slot retires. busy falls together with done.
- An asynchronous reset mid-drain returns the block to IDLE with no done pulse.

## Structure
- Shared package judge_pkg:
  - JUDGE_NONE/PERFECT/GOOD/MISS 2-bit constants
  - PERFECT_PTS=2, GOOD_PTS=1
  - state enum {IDLE, RUN, DRAIN}
- Sub-module rr_pick: combinational round-robin picker with inputs req[LANES] and ptr, and outputs one-hot gnt and index. It is reusable by other lane arbiters.
- The top level holds the slots, pointer, FSM and saturating accumulators.

## Test plan
- Sequence checks:
  - Start condition: reset, enable=1.
  - Lane 0 posts PERFECT, PERFECT, GOOD on consecutive cycles. Response: score=5, combo=2, max_combo=2. Each score update lands 1 edge after the arrival edge.
  - Lane 2 then posts MISS. Response: combo=0, max_combo=2.
- Contention:
  - All 4 lanes post PERFECT in the same cycle with rr_ptr=0. Response: grants 0,1,2,3 on successive cycles, final score=8, combo=4.
  - Second step: lanes 1 and 3 post together. Response: lane 1 is granted first, since rr_ptr=0 after the wrap.
- Drop: lane 1 posts, then posts again while lanes 0 and 1 are both pending and rr_ptr=0. Response: dropped[1]=1, only one lane-1 judgement is counted, and the flag stays set until clear.
- Drain: three lanes pending when enable falls. Response: busy stays 1, three retirements occur, done pulses once, and arrivals during DRAIN are ignored.
- Saturation: start from score=254 and combo=255, then post PERFECT. Response: score=255, combo=255.
- Clear and reset:
  - clear asserted in the same cycle as an arrival. Response: all counters and slots are 0 and the arrival is lost.
  - Async reset pulsed mid-cycle during DRAIN. Response: immediate IDLE, no done pulse.
